// File: rtl/swim_ctrl.sv
// SWIM command sequencer: turns single-byte UART commands into entry, line-reset
// and bit-engine activity, and answers every command with one status byte.
module swim_ctrl #(
  parameter int ENTRY_TIMEOUT = 300000,
  parameter int RST_CYCLES    = 768,
  parameter int TX_TIMEOUT    = 4800,
  parameter int MAX_RETRY     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       entry_start,
  input  logic       entry_busy,
  output logic       rst_drive,
  output logic       tx_start,
  output logic [2:0] tx_cmd,
  input  logic       tx_done,
  input  logic       tx_nack,
  output logic       busy
);

  localparam int MAX_AB = (ENTRY_TIMEOUT > RST_CYCLES) ? ENTRY_TIMEOUT : RST_CYCLES;
  localparam int MAX_ALL = (MAX_AB > TX_TIMEOUT) ? MAX_AB : TX_TIMEOUT;
  localparam int CW = $clog2(MAX_ALL + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CW-1:0] ENTRY_LAST  = CW'(ENTRY_TIMEOUT - 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TX_LAST     = CW'(TX_TIMEOUT - 1);
  localparam logic [CW-1:0] ENTRY_GUARD = CW'(2);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, ENTRY_START, ENTRY_WAIT, LRST, TX_ISSUE, TX_WAIT, RESP
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic [RW-1:0] retry, retry_nxt;
  logic [7:0]    rsp_q, rsp_nxt;
  logic [2:0]    cmd_q, cmd_nxt;

  // One shared saturating counter times entry wait, line reset and tx wait
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      retry <= '0;
      rsp_q <= 8'h00;
      cmd_q <= 3'b000;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      retry <= retry_nxt;
      rsp_q <= rsp_nxt;
      cmd_q <= cmd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    rsp_nxt   = rsp_q;
    cmd_nxt   = cmd_q;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          retry_nxt = '0;
          cnt_nxt   = '0;
          case (cmd_data)
            8'h01: state_nxt = ENTRY_START;
            8'h02: state_nxt = LRST;
            8'h03: begin
              state_nxt = TX_ISSUE;
              cmd_nxt   = 3'b000;
            end
            8'h00: begin
              state_nxt = RESP;
              rsp_nxt   = 8'h80;
            end
            default: begin
              state_nxt = RESP;
              rsp_nxt   = 8'hFF;
            end
          endcase
        end
      end
      ENTRY_START: begin
        cnt_nxt   = '0;
        state_nxt = ENTRY_WAIT;
      end
      // Done takes priority over timeout so a late falling edge still counts
      ENTRY_WAIT: begin
        if (!entry_busy && cnt >= ENTRY_GUARD) begin
          state_nxt = RESP;
          rsp_nxt   = 8'h81;
        end else if (cnt >= ENTRY_LAST) begin
          state_nxt = RESP;
          rsp_nxt   = 8'hE1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      LRST: begin
        if (cnt >= RST_LAST) begin
          state_nxt = RESP;
          rsp_nxt   = 8'h82;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      TX_ISSUE: begin
        cnt_nxt   = '0;
        state_nxt = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) begin
          if (!tx_nack) begin
            state_nxt = RESP;
            rsp_nxt   = 8'h83;
          end else if (retry < RETRY_MAX) begin
            retry_nxt = retry + 1'b1;
            state_nxt = TX_ISSUE;
          end else begin
            state_nxt = RESP;
            rsp_nxt   = 8'hC3;
          end
        end else if (cnt >= TX_LAST) begin
          state_nxt = RESP;
          rsp_nxt   = 8'hE3;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready   = (state == IDLE) && !reset;
  assign rsp_valid   = (state == RESP);
  assign rsp_data    = rsp_q;
  assign entry_start = (state == ENTRY_START);
  assign rst_drive   = (state == LRST);
  assign tx_start    = (state == TX_ISSUE);
  assign tx_cmd      = cmd_q;
  assign busy        = (state != IDLE);

endmodule
